// File: rtl/cpu.sv
// rtl/cpu.sv - three-stage (IF/ID/EX) RV32I-subset CPU with instruction and data RAM.
// Optional CPU_EXCEPTION_EN: illegal opcodes and misaligned LW/SW/jump targets raise a sticky halt.
module cpu #(
   parameter int REGISTER_FILE_SIZE = 32,
   parameter int DATA_RAM_DEPTH     = 1024,
   parameter int INSTR_RAM_DEPTH    = 1024
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] write_address,
   input  logic [31:0] write_data,
   input  logic        write_enable,
   output logic [31:0] debug_reg [0:REGISTER_FILE_SIZE-1],
   output logic [31:0] ram_debug [DATA_RAM_DEPTH/4],
   output logic        debug_is_bj,
   output logic        debug_flush,
   output logic        debug_exception
);
   localparam int DWORDS = DATA_RAM_DEPTH / 4;
   localparam int IWORDS = INSTR_RAM_DEPTH / 4;
   localparam int DAW    = $clog2(DWORDS);
   localparam int IAW    = $clog2(IWORDS);
   localparam int RAW    = $clog2(REGISTER_FILE_SIZE);
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic [31:0] imem_q [IWORDS];
   logic [31:0] dmem_q [DWORDS];
   logic [31:0] rf_q   [REGISTER_FILE_SIZE];
   logic [31:0] pc_q, pc_d;
   logic        ifid_valid_q, ex_valid_q, exc_q;
   logic [31:0] ifid_instr_q, ifid_pc_q;
   logic [31:0] ex_instr_q, ex_pc_q, ex_rs1_q, ex_rs2_q;

   logic [31:0] if_instr, id_rs1_val, id_rs2_val;
   logic [4:0]  id_rs1, id_rs2, rd;
   logic [6:0]  opc;
   logic [2:0]  f3;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [31:0] alu_b, alu_res, mem_addr, target, wb_data;
   logic        is_lui, is_auipc, is_opi, is_op, is_load, is_store, is_br, is_jal, is_jalr;
   logic        legal, br_cond, taken_raw, exc_now, ex_go, taken, halt, wb_en, st_en;
   logic [DAW-1:0] daddr;
   logic        unused_bits;

   assign debug_reg = rf_q;
   assign ram_debug = dmem_q;

   always_comb begin
      if_instr = NOP;
      if (pc_q[31:2] < 30'(IWORDS)) if_instr = imem_q[pc_q[IAW+1:2]];
   end

   // Register read with same-cycle bypass of the EX write-back.
   assign id_rs1 = ifid_instr_q[19:15];
   assign id_rs2 = ifid_instr_q[24:20];
   always_comb begin
      id_rs1_val = 32'b0;
      id_rs2_val = 32'b0;
      if (id_rs1 != 5'd0 && int'(id_rs1) < REGISTER_FILE_SIZE) id_rs1_val = rf_q[id_rs1[RAW-1:0]];
      if (id_rs2 != 5'd0 && int'(id_rs2) < REGISTER_FILE_SIZE) id_rs2_val = rf_q[id_rs2[RAW-1:0]];
      if (wb_en && rd == id_rs1) id_rs1_val = wb_data;
      if (wb_en && rd == id_rs2) id_rs2_val = wb_data;
   end

   assign opc   = ex_instr_q[6:0];
   assign f3    = ex_instr_q[14:12];
   assign rd    = ex_instr_q[11:7];
   assign imm_i = {{20{ex_instr_q[31]}}, ex_instr_q[31:20]};
   assign imm_s = {{20{ex_instr_q[31]}}, ex_instr_q[31:25], ex_instr_q[11:7]};
   assign imm_b = {{19{ex_instr_q[31]}}, ex_instr_q[31], ex_instr_q[7], ex_instr_q[30:25], ex_instr_q[11:8], 1'b0};
   assign imm_u = {ex_instr_q[31:12], 12'b0};
   assign imm_j = {{11{ex_instr_q[31]}}, ex_instr_q[31], ex_instr_q[19:12], ex_instr_q[20], ex_instr_q[30:21], 1'b0};

   assign is_lui   = opc == 7'b0110111;
   assign is_auipc = opc == 7'b0010111;
   assign is_opi   = opc == 7'b0010011;
   assign is_op    = opc == 7'b0110011;
   assign is_load  = opc == 7'b0000011;
   assign is_store = opc == 7'b0100011;
   assign is_br    = opc == 7'b1100011;
   assign is_jal   = opc == 7'b1101111;
   assign is_jalr  = opc == 7'b1100111;
   assign legal    = is_lui | is_auipc | is_opi | is_op | is_load | is_store | is_br | is_jal | is_jalr;

   assign alu_b = is_op ? ex_rs2_q : imm_i;
   always_comb begin
      alu_res = 32'b0;
      case (f3)
         3'b000: alu_res = (is_op && ex_instr_q[30]) ? ex_rs1_q - alu_b : ex_rs1_q + alu_b;
         3'b001: alu_res = ex_rs1_q << alu_b[4:0];
         3'b010: alu_res = {31'b0, $signed(ex_rs1_q) < $signed(alu_b)};
         3'b011: alu_res = {31'b0, ex_rs1_q < alu_b};
         3'b100: alu_res = ex_rs1_q ^ alu_b;
         3'b101: alu_res = ex_instr_q[30] ? 32'($signed(ex_rs1_q) >>> alu_b[4:0]) : ex_rs1_q >> alu_b[4:0];
         3'b110: alu_res = ex_rs1_q | alu_b;
         default: alu_res = ex_rs1_q & alu_b;
      endcase
   end

   always_comb begin
      br_cond = 1'b0;
      case (f3)
         3'b000: br_cond = ex_rs1_q == ex_rs2_q;
         3'b001: br_cond = ex_rs1_q != ex_rs2_q;
         3'b100: br_cond = $signed(ex_rs1_q) < $signed(ex_rs2_q);
         3'b101: br_cond = $signed(ex_rs1_q) >= $signed(ex_rs2_q);
         3'b110: br_cond = ex_rs1_q < ex_rs2_q;
         3'b111: br_cond = ex_rs1_q >= ex_rs2_q;
         default: br_cond = 1'b0;
      endcase
   end

   assign mem_addr  = ex_rs1_q + (is_store ? imm_s : imm_i);
   assign daddr     = mem_addr[DAW+1:2];
   assign target    = is_jalr ? ((ex_rs1_q + imm_i) & ~32'd1) : ex_pc_q + (is_jal ? imm_j : imm_b);
   assign taken_raw = is_jal | is_jalr | (is_br & br_cond);

`ifdef CPU_EXCEPTION_EN
   assign exc_now = ex_valid_q & (~legal | ((is_load | is_store) & (mem_addr[1:0] != 2'b00))
                                 | (taken_raw & (target[1:0] != 2'b00)));
   assign debug_exception = exc_q;
`else
   assign exc_now = 1'b0;
   assign debug_exception = 1'b0;
`endif

   assign ex_go       = ex_valid_q & ~exc_now & ~exc_q;
   assign taken       = ex_go & taken_raw;
   assign halt        = exc_q | exc_now;
   assign wb_en       = ex_go & (rd != 5'd0) & (int'(rd) < REGISTER_FILE_SIZE)
                        & (is_lui | is_auipc | is_opi | is_op | is_load | is_jal | is_jalr);
   assign st_en       = ex_go & is_store & ~reset_n;
   assign debug_is_bj = ex_valid_q & ~reset_n & (is_br | is_jal | is_jalr);
   assign debug_flush = taken & ~reset_n;
   assign unused_bits = ^{write_address[1:0], mem_addr[1:0], mem_addr[31:DAW+2], legal};

   always_comb begin
      wb_data = alu_res;
      if (is_lui)              wb_data = imm_u;
      else if (is_auipc)       wb_data = ex_pc_q + imm_u;
      else if (is_load)        wb_data = dmem_q[daddr];
      else if (is_jal|is_jalr) wb_data = ex_pc_q + 32'd4;
   end

   always_comb begin
      pc_d = pc_q + 32'd4;
      if (halt)       pc_d = pc_q;
      else if (taken) pc_d = target;
   end

   // RAM contents survive reset; instruction loads stay open during reset.
   always_ff @(posedge clk) begin
      if (write_enable && write_address[31:2] < 30'(IWORDS)) imem_q[write_address[IAW+1:2]] <= write_data;
      if (st_en) dmem_q[daddr] <= ex_rs2_q;
   end

   always_ff @(posedge clk) begin
      if (reset_n) begin
         for (int i = 0; i < REGISTER_FILE_SIZE; i++) rf_q[i] <= '0;
      end else if (wb_en) begin
         rf_q[rd[RAW-1:0]] <= wb_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset_n) begin
         pc_q         <= '0;
         exc_q        <= 1'b0;
         ifid_valid_q <= 1'b0;
         ifid_instr_q <= NOP;
         ifid_pc_q    <= '0;
         ex_valid_q   <= 1'b0;
         ex_instr_q   <= NOP;
         ex_pc_q      <= '0;
         ex_rs1_q     <= '0;
         ex_rs2_q     <= '0;
      end else begin
         pc_q  <= pc_d;
         exc_q <= exc_q | exc_now;
         if (halt || taken) begin
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= NOP;
            ex_valid_q   <= 1'b0;
            ex_instr_q   <= NOP;
         end else begin
            ifid_valid_q <= 1'b1;
            ifid_instr_q <= if_instr;
            ifid_pc_q    <= pc_q;
            ex_valid_q   <= ifid_valid_q;
            ex_instr_q   <= ifid_instr_q;
            ex_pc_q      <= ifid_pc_q;
            ex_rs1_q     <= id_rs1_val;
            ex_rs2_q     <= id_rs2_val;
         end
      end
   end
endmodule

// File: tb/tb_cpu.sv
// tb/tb_cpu.sv - scoreboard testbench for cpu: directed programs, queued expectations, negedge monitor.
module tb_cpu;
   localparam int RF = 32, DD = 1024, ID = 1024, DW = DD / 4;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic [31:0] write_address = '0, write_data = '0;
   logic        write_enable = 1'b0;
   logic [31:0] dbg_reg [0:RF-1];
   logic [31:0] ram_dbg [DW];
   logic        is_bj, flush, exc;

   cpu #(.REGISTER_FILE_SIZE(RF), .DATA_RAM_DEPTH(DD), .INSTR_RAM_DEPTH(ID)) dut (
      .clk(clk), .reset_n(reset_n), .write_address(write_address), .write_data(write_data),
      .write_enable(write_enable), .debug_reg(dbg_reg), .ram_debug(ram_dbg),
      .debug_is_bj(is_bj), .debug_flush(flush), .debug_exception(exc));

   always #5 clk = ~clk;

   typedef struct { string name; int kind; int idx; logic [31:0] val; } exp_t;
   exp_t chk_q[$];
   logic bj_q[$];
   int n_chk = 0, n_fail = 0, req_cnt = 0, done_cnt = 0;

   // Encoders
   function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3, input int rd, input logic [6:0] op);
      logic [31:0] m; m = imm;
      return {m[11:0], 5'(rs1), 3'(f3), 5'(rd), op};
   endfunction
   function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1, input int f3, input int rd);
      return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'b0110011};
   endfunction
   function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
      logic [31:0] m; m = imm;
      return {m[11:5], 5'(rs2), 5'(rs1), 3'b010, m[4:0], 7'b0100011};
   endfunction
   function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
      logic [31:0] m; m = imm;
      return {m[12], m[10:5], 5'(rs2), 5'(rs1), 3'(f3), m[4:1], m[11], 7'b1100011};
   endfunction
   function automatic logic [31:0] enc_j(input int imm, input int rd);
      logic [31:0] m; m = imm;
      return {m[20], m[10:1], m[11], m[19:12], 5'(rd), 7'b1101111};
   endfunction
   function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
      return enc_i(imm, rs1, 0, rd, 7'b0010011);
   endfunction

   // Monitor: flush/branch events against bj_q, state snapshots against chk_q.
   always @(negedge clk) begin
      exp_t e;
      logic ef;
      logic [31:0] act;
      n_chk++;
      if (is_bj) begin
         if (bj_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_bj: debug_is_bj=1 debug_flush=%0b, required no branch/jump in EX", flush);
         end else begin
            ef = bj_q.pop_front();
            if (flush !== ef) begin
               n_fail++;
               $display("FAIL bj_flush: debug_flush=%0b, required %0b", flush, ef);
            end
         end
      end else if (flush !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_without_bj: debug_flush=%0b, required 0", flush);
      end
      if (done_cnt != req_cnt) begin
         while (chk_q.size() > 0) begin
            e = chk_q.pop_front();
            case (e.kind)
               0: act = dbg_reg[e.idx];
               1: act = ram_dbg[e.idx];
               2: act = {31'b0, exc};
               3: act = {31'b0, is_bj};
               default: act = {31'b0, flush};
            endcase
            n_chk++;
            if (act !== e.val) begin
               n_fail++;
               $display("FAIL %s: got 0x%08h, required 0x%08h", e.name, act, e.val);
            end
         end
         done_cnt = req_cnt;
      end
   end

   task automatic expect_val(input string name, input int kind, input int idx, input logic [31:0] val);
      exp_t e;
      e.name = name; e.kind = kind; e.idx = idx; e.val = val;
      chk_q.push_back(e);
   endtask

   task automatic run(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic sync_checks();
      req_cnt++;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         if (done_cnt == req_cnt) break;
      end
      if (done_cnt != req_cnt) begin
         n_chk++; n_fail++;
         $display("FAIL check_timeout: monitor did not consume %0d expectations", chk_q.size());
         chk_q.delete();
         done_cnt = req_cnt;
      end
   endtask

   task automatic load_prog(input logic [31:0] prog [$]);
      reset_n = 1'b1;
      for (int i = 0; i < 32; i++) begin
         write_enable  = 1'b1;
         write_address = 32'(i * 4);
         write_data    = (i < prog.size()) ? prog[i] : NOP;
         @(posedge clk); #1;
      end
      write_enable = 1'b0;
      reset_n      = 1'b0;
   endtask

   task automatic end_test(input string name);
      n_chk++;
      if (bj_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s_bj_left: %0d expected branch events not seen, required 0", name, bj_q.size());
      end
      bj_q.delete();
   endtask

   initial begin
      logic [31:0] p [$];
      for (int i = 0; i < ID / 4; i++) begin
         write_enable = 1'b1; write_address = 32'(i * 4); write_data = NOP;
         @(posedge clk); #1;
      end
      write_enable = 1'b0;
      expect_val("rst_x1", 0, 1, 0); expect_val("rst_x31", 0, 31, 0);
      expect_val("rst_is_bj", 3, 0, 0); expect_val("rst_flush", 4, 0, 0); expect_val("rst_exc", 2, 0, 0);
      sync_checks();

      // ADDI chain through the bypass, no stall
      p = '{addi(1, 0, 5), addi(2, 1, 3)};
      load_prog(p);
      run(3);
      expect_val("chain_x1", 0, 1, 32'd5); expect_val("chain_x2_early", 0, 2, 32'd0);
      sync_checks();
      run(1);
      expect_val("chain_x2", 0, 2, 32'd8);
      sync_checks();
      run(6);
      end_test("chain");

      // Mid-program reset restarts at address 0
      reset_n = 1'b1;
      run(1);
      expect_val("midrst_x1", 0, 1, 0); expect_val("midrst_x2", 0, 2, 0);
      sync_checks();
      reset_n = 1'b0;
      run(3);
      expect_val("restart_x1", 0, 1, 32'd5);
      sync_checks();
      run(1);
      expect_val("restart_x2", 0, 2, 32'd8);
      sync_checks();
      end_test("restart");

      // BEQ taken
      p = '{enc_b(8, 0, 0, 0), addi(1, 0, 1), addi(2, 0, 2)};
      load_prog(p);
      bj_q.push_back(1'b1);
      run(10);
      expect_val("beq_skip_x1", 0, 1, 0); expect_val("beq_x2", 0, 2, 32'd2);
      sync_checks();
      end_test("beq");

      // BNE not taken
      p = '{enc_b(8, 0, 0, 1), addi(1, 0, 1), addi(2, 0, 2)};
      load_prog(p);
      bj_q.push_back(1'b0);
      run(10);
      expect_val("bne_x1", 0, 1, 32'd1); expect_val("bne_x2", 0, 2, 32'd2);
      sync_checks();
      end_test("bne");

      // Store then load
      p = '{addi(1, 0, 32'h55), enc_s(4, 1, 0), enc_i(4, 0, 2, 3, 7'b0000011)};
      load_prog(p);
      run(10);
      expect_val("sw_ram1", 1, 1, 32'h55); expect_val("lw_x3", 0, 3, 32'h55);
      sync_checks();
      end_test("mem");

      // JAL at 0x10
      p = '{NOP, NOP, NOP, NOP, enc_j(12, 5), addi(6, 0, 1), addi(7, 0, 1), addi(8, 0, 9)};
      load_prog(p);
      bj_q.push_back(1'b1);
      run(14);
      expect_val("jal_x5", 0, 5, 32'h14); expect_val("jal_skip_x6", 0, 6, 0);
      expect_val("jal_skip_x7", 0, 7, 0); expect_val("jal_x8", 0, 8, 32'd9);
      sync_checks();
      end_test("jal");

      // ALU mix
      p = '{addi(1, 0, -8), enc_i(32'h401, 1, 5, 2, 7'b0010011), enc_i(28, 1, 5, 3, 7'b0010011),
            enc_r(32, 1, 0, 0, 4), enc_r(0, 0, 1, 2, 5), enc_r(0, 0, 1, 3, 6),
            {20'h12345, 5'd7, 7'b0110111}, {20'h00001, 5'd8, 7'b0010111}, enc_r(0, 4, 1, 4, 9),
            addi(0, 0, 5), enc_r(0, 3, 3, 1, 10), enc_r(32, 3, 1, 5, 11),
            enc_i(32'h0F0, 1, 7, 12, 7'b0010011), enc_i(-1, 0, 6, 13, 7'b0010011)};
      load_prog(p);
      run(20);
      expect_val("addi_neg", 0, 1, 32'hFFFF_FFF8); expect_val("srai", 0, 2, 32'hFFFF_FFFC);
      expect_val("srli", 0, 3, 32'h0000_000F);     expect_val("sub", 0, 4, 32'd8);
      expect_val("slt", 0, 5, 32'd1);              expect_val("sltu", 0, 6, 32'd0);
      expect_val("lui", 0, 7, 32'h1234_5000);      expect_val("auipc", 0, 8, 32'h0000_101C);
      expect_val("xor", 0, 9, 32'hFFFF_FFF0);      expect_val("x0_zero", 0, 0, 32'd0);
      expect_val("sll", 0, 10, 32'h0007_8000);     expect_val("sra", 0, 11, 32'hFFFF_FFFF);
      expect_val("andi", 0, 12, 32'h0000_00F0);    expect_val("ori", 0, 13, 32'hFFFF_FFFF);
      sync_checks();
      end_test("alu");

      // JALR clears bit 0 of the target
      p = '{addi(1, 0, 32'h11), enc_i(0, 1, 0, 2, 7'b1100111), addi(3, 0, 1), addi(4, 0, 1), addi(5, 0, 7)};
      load_prog(p);
      bj_q.push_back(1'b1);
      run(12);
      expect_val("jalr_x2", 0, 2, 32'h8); expect_val("jalr_skip_x3", 0, 3, 0);
      expect_val("jalr_skip_x4", 0, 4, 0); expect_val("jalr_x5", 0, 5, 32'd7);
      sync_checks();
      end_test("jalr");

      // BLT signed and BGEU unsigned, both taken
      p = '{addi(1, 0, -1), enc_b(8, 0, 1, 4), addi(2, 0, 1), enc_b(8, 0, 1, 7), addi(3, 0, 1), addi(4, 0, 4)};
      load_prog(p);
      bj_q.push_back(1'b1); bj_q.push_back(1'b1);
      run(14);
      expect_val("blt_skip_x2", 0, 2, 0); expect_val("bgeu_skip_x3", 0, 3, 0);
      expect_val("br_x4", 0, 4, 32'd4);
      sync_checks();
      end_test("brs");

      // Illegal opcode
      p = '{32'hFFFF_FFFF, addi(1, 0, 3)};
      load_prog(p);
      run(8);
`ifdef CPU_EXCEPTION_EN
      expect_val("exc_set", 2, 0, 1); expect_val("exc_suppress_x1", 0, 1, 0);
      sync_checks();
      run(5);
      expect_val("exc_sticky", 2, 0, 1);
      sync_checks();
      reset_n = 1'b1;
      run(1);
      expect_val("exc_cleared", 2, 0, 0);
      sync_checks();
      reset_n = 1'b0;
`else
      expect_val("illegal_no_exc", 2, 0, 0); expect_val("illegal_nop_x1", 0, 1, 32'd3);
      sync_checks();
`endif
      end_test("illegal");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end
endmodule
